// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Data-memory handshake between the load/store unit and the data memory.
// The unit raises a request with a word address, byte enables and store
// data, and holds them stable until the memory answers with an ack. The ack
// cycle also carries the read word.
//   master (load/store unit): drives mem_req_o, mem_we_o, mem_addr_o,
//                             mem_be_o, mem_wdata_o; samples mem_ack_i, mem_rdata_i
//   slave  (data memory)    : the mirror image
interface load_store_unit_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// MEM-stage load/store unit. Turns one load or store into a single
// word-aligned request on the data-memory handshake, stalls the pipeline
// until the memory acks, and returns a lane-extracted, sign- or
// zero-extended load result.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   valid_i               MEM stage holds a live instruction
//   mem_read_i/write_i    load / store (store wins if both are set)
//   mem_width_i           00 byte, 01 half, 10 word, 11 illegal
//   mem_sign_extend_i     sign-extend the load result
//   addr_i, wdata_i       byte address and store data
//   stall_o               freeze the upstream pipeline registers
//   rdata_o               formatted load result (registered)
//   err_o                 one-cycle pulse for misaligned/illegal access
//   mem                   data-memory handshake (master side)
module load_store_unit (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  input  logic                     mem_read_i,
  input  logic                     mem_write_i,
  input  logic [1:0]               mem_width_i,
  input  logic                     mem_sign_extend_i,
  input  logic [31:0]              addr_i,
  input  logic [31:0]              wdata_i,
  output logic                     stall_o,
  output logic [31:0]              rdata_o,
  output logic                     err_o,
  load_store_unit_if.master        mem
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic        start;
  logic        fault;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [1:0]  width_q;
  logic        sign_q;
  logic [1:0]  off_q;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_fmt;

  // An access starts whenever a live instruction is a load or a store.
  // Misalignment is judged against the natural alignment of the width;
  // width 11 is always illegal.
  always_comb begin
    start = valid_i & (mem_read_i | mem_write_i);
    fault = (mem_width_i == 2'b11) |
            ((mem_width_i == 2'b01) & addr_i[0]) |
            ((mem_width_i == 2'b10) & (addr_i[1:0] != 2'b00));
  end

  // The stall covers the issuing IDLE cycle and every BUSY cycle, so the
  // instruction stays in MEM until DONE, where the result is already
  // registered. Nothing is stalled while reset is held.
  always_comb begin
    stall_o = ~rst_i & (((state == IDLE) & start & ~fault) | (state == BUSY));
  end

  // Byte enables and lane-replicated store data so memory can take the
  // bytes from whichever lane the enables select.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata_i;
    case (mem_width_i)
      2'b00: begin
        be_next    = 4'b0001 << addr_i[1:0];
        wdata_next = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << addr_i[1:0];
        wdata_next = {2{wdata_i[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wdata_i;
      end
    endcase
  end

  // Load formatting uses the width, sign and offset latched at issue time,
  // since the inputs are not trusted once the request is out.
  always_comb begin
    byte_lane = mem.mem_rdata_i[{off_q, 3'b000} +: 8];
    half_lane = off_q[1] ? mem.mem_rdata_i[31:16] : mem.mem_rdata_i[15:0];
    case (width_q)
      2'b00:   load_fmt = {{24{sign_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_fmt = {{16{sign_q & half_lane[15]}}, half_lane};
      default: load_fmt = mem.mem_rdata_i;
    endcase
  end

  // Access FSM with registered memory-side outputs. A faulted access never
  // leaves IDLE; it only pulses err_o and clears rdata_o. DONE always
  // returns to IDLE without looking at start, because the instruction
  // that was just served is still presented during DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      rdata_o         <= 32'd0;
      err_o           <= 1'b0;
      mem.mem_req_o   <= 1'b0;
      mem.mem_we_o    <= 1'b0;
      mem.mem_addr_o  <= 32'd0;
      mem.mem_be_o    <= 4'd0;
      mem.mem_wdata_o <= 32'd0;
      width_q         <= 2'd0;
      sign_q          <= 1'b0;
      off_q           <= 2'd0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (fault) begin
              err_o   <= 1'b1;
              rdata_o <= 32'd0;
            end else begin
              state           <= BUSY;
              mem.mem_req_o   <= 1'b1;
              mem.mem_we_o    <= mem_write_i;
              mem.mem_addr_o  <= {addr_i[31:2], 2'b00};
              mem.mem_be_o    <= be_next;
              mem.mem_wdata_o <= wdata_next;
              width_q         <= mem_width_i;
              sign_q          <= mem_sign_extend_i;
              off_q           <= addr_i[1:0];
            end
          end
        end
        BUSY: begin
          if (mem.mem_ack_i) begin
            mem.mem_req_o <= 1'b0;
            if (!mem.mem_we_o) begin
              rdata_o <= load_fmt;
            end
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Directed bench for load_store_unit. Expected outputs come from a small
// arithmetic model of the access rules; a compare process checks the DUT
// against the expected values every cycle, and literal values pin the model.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [1:0]  mem_width_i;
  logic        mem_sign_extend_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        err_o;

  load_store_unit_if mem_if();

  load_store_unit dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .valid_i           (valid_i),
    .mem_read_i        (mem_read_i),
    .mem_write_i       (mem_write_i),
    .mem_width_i       (mem_width_i),
    .mem_sign_extend_i (mem_sign_extend_i),
    .addr_i            (addr_i),
    .wdata_i           (wdata_i),
    .stall_o           (stall_o),
    .rdata_o           (rdata_o),
    .err_o             (err_o),
    .mem               (mem_if)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // expected outputs for the current cycle
  logic        exp_stall, exp_req, exp_err, exp_we;
  logic [31:0] exp_rdata, exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  bit          check_en = 1'b0;

  // observations used for literal and timing checks
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_be;
  logic        seen_we;
  logic        prev_req = 1'b0;
  int          cycle = 0;
  int          stall_cnt = 0;
  int          req_rise_cycle = 0;
  int          last_done_cycle = 0;

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int nbytes(input logic [1:0] w);
    return 1 << w;
  endfunction

  function automatic bit model_fault(input logic [1:0] w, input logic [31:0] a);
    if (w == 2'b11) return 1'b1;
    return (a % nbytes(w)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] w, input logic [31:0] a);
    int n;
    n = nbytes(w);
    return 4'(((1 << n) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] w, input logic [31:0] d);
    logic [31:0] r;
    int n;
    n = nbytes(w);
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] w, input bit sgn,
                                             input logic [31:0] a, input logic [31:0] word);
    logic [31:0] v, mask;
    int n;
    n = nbytes(w);
    if (n == 4) return word;
    v    = word >> (8 * a[1:0]);
    mask = (32'h1 << (8 * n)) - 32'h1;
    v    = v & mask;
    if (sgn && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  always @(posedge clk_i) cycle++;

  // Per-cycle comparison against the expected values, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (check_en) begin
      checkOutput("stall", {31'd0, stall_o}, {31'd0, exp_stall});
      checkOutput("req", {31'd0, mem_if.mem_req_o}, {31'd0, exp_req});
      checkOutput("err", {31'd0, err_o}, {31'd0, exp_err});
      checkOutput("rdata", rdata_o, exp_rdata);
      if (exp_req) begin
        checkOutput("addr", mem_if.mem_addr_o, exp_addr);
        checkOutput("be", {28'd0, mem_if.mem_be_o}, {28'd0, exp_be});
        checkOutput("we", {31'd0, mem_if.mem_we_o}, {31'd0, exp_we});
        if (exp_we) checkOutput("wdata", mem_if.mem_wdata_o, exp_wdata);
      end
    end
    if (stall_o) stall_cnt++;
    if (mem_if.mem_req_o && !prev_req) req_rise_cycle = cycle;
    prev_req = mem_if.mem_req_o;
    if (mem_if.mem_req_o) begin
      seen_addr  = mem_if.mem_addr_o;
      seen_be    = mem_if.mem_be_o;
      seen_wdata = mem_if.mem_wdata_o;
      seen_we    = mem_if.mem_we_o;
    end
  end

  // Cycles with no memory access; optionally a live non-memory instruction
  // and a stray ack that must be ignored.
  task automatic idleCycles(input int n, input bit v, input bit ack);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      valid_i = v; mem_read_i = 1'b0; mem_write_i = 1'b0;
      mem_if.mem_ack_i = ack;
      exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0;
    end
    mem_if.mem_ack_i = 1'b0;
  endtask

  // One complete access. ack_cycle is the BUSY cycle (1-based) in which
  // memory acks; memword is the word memory returns.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [1:0] w,
                               input bit sgn, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] memword,
                               input int ack_cycle);
    bit f;
    f = (rd || wr) && model_fault(w, a);
    @(posedge clk_i); #1;
    valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; mem_width_i = w;
    mem_sign_extend_i = sgn; addr_i = a; wdata_i = d;
    mem_if.mem_ack_i = 1'b0; mem_if.mem_rdata_i = memword;
    exp_stall = !f; exp_req = 1'b0; exp_err = 1'b0;
    stall_cnt = 0;
    if (f) begin
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      exp_stall = 1'b0; exp_err = 1'b1; exp_rdata = 32'd0;
      @(posedge clk_i); #1;
      exp_err = 1'b0;
      checkOutput("fault_stall_cycles", stall_cnt, 0);
    end else begin
      exp_addr  = {a[31:2], 2'b00};
      exp_be    = model_be(w, a);
      exp_wdata = model_wdata(w, d);
      exp_we    = wr;
      for (int i = 1; i <= ack_cycle; i++) begin
        @(posedge clk_i); #1;
        exp_req = 1'b1; exp_stall = 1'b1;
        mem_if.mem_ack_i = (i == ack_cycle);
      end
      @(posedge clk_i); #1;
      last_done_cycle = cycle;
      mem_if.mem_ack_i = 1'b0;
      exp_req = 1'b0; exp_stall = 1'b0;
      if (!wr) exp_rdata = model_load(w, sgn, a, memword);
      @(negedge clk_i); #1;
      checkOutput("stall_cycles", stall_cnt, ack_cycle + 1);
    end
  endtask

  int first_done;

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    mem_width_i = 2'b00; mem_sign_extend_i = 1'b0; addr_i = '0; wdata_i = '0;
    mem_if.mem_ack_i = 1'b0; mem_if.mem_rdata_i = '0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_we = 1'b0;
    exp_rdata = '0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
    check_en = 1'b1;

    // reset values
    @(negedge clk_i); #1;
    checkOutput("rst_addr", mem_if.mem_addr_o, 32'd0);
    checkOutput("rst_be", {28'd0, mem_if.mem_be_o}, 32'd0);
    checkOutput("rst_wdata", mem_if.mem_wdata_o, 32'd0);
    checkOutput("rst_we", {31'd0, mem_if.mem_we_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // store byte at 0x103, ack in BUSY cycle 1
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5, 32'h0, 1);
    checkOutput("sb_addr_lit", seen_addr, 32'h100);
    checkOutput("sb_be_lit", {28'd0, seen_be}, 32'h8);
    checkOutput("sb_wdata_lit", seen_wdata, 32'hA5A5A5A5);
    checkOutput("sb_we_lit", {31'd0, seen_we}, 32'h1);
    checkOutput("sb_rdata_lit", rdata_o, 32'h0);

    // byte loads at 0x202, signed then unsigned
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h202, 32'h0, 32'h12F03456, 1);
    checkOutput("lb_lit", rdata_o, 32'hFFFFFFF0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h202, 32'h0, 32'h12F03456, 2);
    checkOutput("lbu_lit", rdata_o, 32'h000000F0);

    // signed half load at 0x2, ack delayed to BUSY cycle 5
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 32'h2, 32'h0, 32'h80010000, 5);
    checkOutput("lh_lit", rdata_o, 32'hFFFF8001);
    checkOutput("lh_be_lit", {28'd0, seen_be}, 32'hC);

    // misaligned word load clears rdata and pulses err
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h1002, 32'h0, 32'h0, 1);
    checkOutput("lw_fault_rdata_lit", rdata_o, 32'h0);

    // unsigned half at offset 0, then stray ack and non-memory instruction
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h2000, 32'h0, 32'h1234ABCD, 1);
    checkOutput("lhu_lit", rdata_o, 32'h0000ABCD);
    idleCycles(2, 1'b0, 1'b1);
    idleCycles(2, 1'b1, 1'b0);

    // illegal width and misaligned half store
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 32'h1000, 32'h0, 32'h0, 1);
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h101, 32'h1234, 32'h0, 1);
    idleCycles(1, 1'b0, 1'b0);

    // back-to-back store then load of the same word
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1);
    first_done = last_done_cycle;
    checkOutput("sw_wdata_lit", seen_wdata, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, seen_wdata, 1);
    checkOutput("b2b_gap", req_rise_cycle - first_done, 2);
    checkOutput("b2b_rdata_lit", rdata_o, 32'hDEADBEEF);

    // reset while BUSY, then a late ack
    @(posedge clk_i); #1;
    valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; mem_width_i = 2'b10;
    mem_sign_extend_i = 1'b0; addr_i = 32'h40; mem_if.mem_rdata_i = 32'h55;
    exp_stall = 1'b1; exp_req = 1'b0; exp_err = 1'b0;
    exp_addr = 32'h40; exp_be = 4'hF; exp_we = 1'b0;
    repeat (2) begin
      @(posedge clk_i); #1;
      exp_req = 1'b1; exp_stall = 1'b1;
    end
    @(posedge clk_i); #1;
    rst_i = 1'b1; valid_i = 1'b0;
    exp_req = 1'b0; exp_stall = 1'b0; exp_rdata = 32'd0;
    #1;
    checkOutput("rst_busy_req", {31'd0, mem_if.mem_req_o}, 32'h0);
    checkOutput("rst_busy_stall", {31'd0, stall_o}, 32'h0);
    checkOutput("rst_busy_addr", mem_if.mem_addr_o, 32'h0);
    checkOutput("rst_busy_be", {28'd0, mem_if.mem_be_o}, 32'h0);
    checkOutput("rst_busy_rdata", rdata_o, 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    mem_if.mem_ack_i = 1'b1;
    @(posedge clk_i); #1;
    mem_if.mem_ack_i = 1'b0;
    idleCycles(3, 1'b0, 1'b0);
    @(negedge clk_i); #1;
    check_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
